// File: rtl/membus_arbiter_n_pkg.sv
// Shared types and helpers for the membus_arbiter_n codebase slice.
// Optional feature macro: MEMBUS_ARB_PRIO0_EN (channel 0 fixed priority).
package membus_arbiter_n_pkg;

  localparam int DEF_NUM_CH          = 32'sd2;
  localparam int DEF_MAX_OUTSTANDING = 32'sd4;
  localparam int DEF_ADDR_W          = 32'sd32;
  localparam int DEF_DATA_W          = 32'sd32;

  // Grant lock state: FREE re-arbitrates every cycle, LOCKED holds a pending grant.
  typedef enum logic [0:0] {
    ARB_FREE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // Width of an index into n entries; never zero so single-entry cases stay legal.
  function automatic int id_width(input int n);
    return (n > 32'sd1) ? $clog2(n) : 32'sd1;
  endfunction

  // Increment with wrap at modulus (modulus need not be a power of two).
  function automatic int wrap_inc(input int val, input int modulus);
    return ((val + 32'sd1) >= modulus) ? 32'sd0 : (val + 32'sd1);
  endfunction

endpackage

// File: rtl/membus_arbiter_n_id_fifo.sv
// In-order FIFO of channel IDs for accepted-but-unanswered memory requests.
// Push/pop are self-gated against full/empty so callers cannot corrupt state.
module membus_arbiter_n_id_fifo
  import membus_arbiter_n_pkg::*;
#(
  parameter int DEPTH = DEF_MAX_OUTSTANDING,
  parameter int W     = 32'sd1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] pop_data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int PW = id_width(DEPTH);
  localparam int CW = $clog2(DEPTH + 32'sd1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          push_s;
  logic          pop_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 32'sd1)) ? '0 : (p + PW'(1));
  endfunction

  assign full_o     = (count_q == CW'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign push_s     = push_i && !full_o;
  assign pop_s      = pop_i && !empty_o;
  assign pop_data_o = mem_q[rd_ptr_q];

  // Storage: write the pushed ID at the tail.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_s) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Pointers and occupancy; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (pop_s) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      case ({push_s, pop_s})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/membus_arbiter_n.sv
// N-channel round-robin arbiter onto one memory bus with in-order response routing.
// Optional feature macro: MEMBUS_ARB_PRIO0_EN -- channel 0 wins whenever valid and
// unlocked; round-robin then rotates over channels 1..NUM_CH-1 only.
module membus_arbiter_n
  import membus_arbiter_n_pkg::*;
#(
  parameter int NUM_CH          = DEF_NUM_CH,
  parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
  parameter int ADDR_W          = DEF_ADDR_W,
  parameter int DATA_W          = DEF_DATA_W
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_CH-1:0]        ch_req_valid,
  output logic [NUM_CH-1:0]        ch_req_ready,
  input  logic [NUM_CH*ADDR_W-1:0] ch_req_addr,
  input  logic [NUM_CH-1:0]        ch_req_wen,
  input  logic [NUM_CH*DATA_W-1:0] ch_req_wdata,
  output logic [NUM_CH-1:0]        ch_resp_valid,
  output logic                     ch_resp_error,
  output logic [ADDR_W-1:0]        ch_resp_addr,
  output logic [DATA_W-1:0]        ch_resp_rdata,
  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic [ADDR_W-1:0]        mem_req_addr,
  output logic                     mem_req_wen,
  output logic [DATA_W-1:0]        mem_req_wdata,
  input  logic                     mem_resp_valid,
  input  logic                     mem_resp_error,
  input  logic [ADDR_W-1:0]        mem_resp_addr,
  input  logic [DATA_W-1:0]        mem_resp_rdata,
  output logic                     orphan_resp
);

  localparam int CH_W = id_width(NUM_CH);
  typedef logic [CH_W-1:0] ch_id_t;

  arb_state_e state_q;
  ch_id_t     lock_id_q;
  ch_id_t     rr_q;
  logic       orphan_q;

  ch_id_t     rr_pick_s;
  ch_id_t     grant_s;
  ch_id_t     head_s;
  logic       accept_s;
  logic       pop_s;
  logic       fifo_full_s;
  logic       fifo_empty_s;

  // Round-robin pick: first valid channel at or after the pointer, wrapping.
  always_comb begin
    int     idx_v;
    logic   found_v;
    ch_id_t cand_v;
    rr_pick_s = '0;
    found_v   = 1'b0;
    idx_v     = 32'sd0;
    cand_v    = '0;
`ifdef MEMBUS_ARB_PRIO0_EN
    for (int k = 0; k < NUM_CH - 1; k++) begin
      idx_v = ((rr_q == '0) ? 32'sd1 : int'(rr_q)) + k;
      if (idx_v >= NUM_CH) begin
        idx_v = idx_v - (NUM_CH - 32'sd1);
      end else begin
        idx_v = idx_v;
      end
      cand_v = ch_id_t'(idx_v);
      if (!found_v && ch_req_valid[cand_v]) begin
        found_v   = 1'b1;
        rr_pick_s = cand_v;
      end else begin
        found_v   = found_v;
      end
    end
    if (ch_req_valid[0]) begin
      rr_pick_s = '0;
    end else begin
      rr_pick_s = rr_pick_s;
    end
`else
    for (int k = 0; k < NUM_CH; k++) begin
      idx_v = int'(rr_q) + k;
      if (idx_v >= NUM_CH) begin
        idx_v = idx_v - NUM_CH;
      end else begin
        idx_v = idx_v;
      end
      cand_v = ch_id_t'(idx_v);
      if (!found_v && ch_req_valid[cand_v]) begin
        found_v   = 1'b1;
        rr_pick_s = cand_v;
      end else begin
        found_v   = found_v;
      end
    end
`endif
  end

  // A pending downstream request keeps its grant; otherwise take the fresh pick.
  assign grant_s       = (state_q == ARB_LOCKED) ? lock_id_q : rr_pick_s;
  assign mem_req_valid = (|ch_req_valid) && !fifo_full_s;
  assign accept_s      = mem_req_valid && mem_req_ready;
  assign pop_s         = mem_resp_valid && !fifo_empty_s;
  assign orphan_resp   = orphan_q;

  // Downstream request mux (zeroed when idle) and shared response pass-through.
  always_comb begin
    if (mem_req_valid) begin
      mem_req_addr  = ch_req_addr[grant_s*ADDR_W +: ADDR_W];
      mem_req_wen   = ch_req_wen[grant_s];
      mem_req_wdata = ch_req_wdata[grant_s*DATA_W +: DATA_W];
    end else begin
      mem_req_addr  = '0;
      mem_req_wen   = 1'b0;
      mem_req_wdata = '0;
    end
    if (pop_s) begin
      ch_resp_error = mem_resp_error;
      ch_resp_addr  = mem_resp_addr;
      ch_resp_rdata = mem_resp_rdata;
    end else begin
      ch_resp_error = 1'b0;
      ch_resp_addr  = '0;
      ch_resp_rdata = '0;
    end
  end

  // One-hot accept strobe to the granted channel and response strobe to the FIFO head.
  always_comb begin
    ch_req_ready  = '0;
    ch_resp_valid = '0;
    if (accept_s) begin
      ch_req_ready[grant_s] = 1'b1;
    end else begin
      ch_req_ready = '0;
    end
    if (pop_s) begin
      ch_resp_valid[head_s] = 1'b1;
    end else begin
      ch_resp_valid = '0;
    end
  end

  // Lock FSM, round-robin pointer and sticky orphan flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ARB_FREE;
      lock_id_q <= '0;
      rr_q      <= '0;
      orphan_q  <= 1'b0;
    end else begin
      case (state_q)
        ARB_FREE: begin
          if (mem_req_valid && !mem_req_ready) begin
            state_q   <= ARB_LOCKED;
            lock_id_q <= grant_s;
          end
        end
        ARB_LOCKED: begin
          if (accept_s) begin
            state_q <= ARB_FREE;
          end
        end
        default: state_q <= ARB_FREE;
      endcase
      if (accept_s) begin
        rr_q <= ch_id_t'(wrap_inc(int'(grant_s), NUM_CH));
      end
      if (mem_resp_valid && fifo_empty_s) begin
        orphan_q <= 1'b1;
      end
    end
  end

  membus_arbiter_n_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .W     (CH_W)
  ) u_id_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (accept_s),
    .push_data_i (grant_s),
    .pop_i       (pop_s),
    .pop_data_o  (head_s),
    .full_o      (fifo_full_s),
    .empty_o     (fifo_empty_s)
  );

endmodule

// File: tb/tb_membus_arbiter_n.sv
// Scoreboard bench for membus_arbiter_n (NUM_CH=3, MAX_OUTSTANDING=4).
module tb_membus_arbiter_n;

  localparam int NCH = 3;
  localparam int MO  = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NCH-1:0]    ch_req_valid;
  logic [NCH-1:0]    ch_req_ready;
  logic [NCH*AW-1:0] ch_req_addr;
  logic [NCH-1:0]    ch_req_wen;
  logic [NCH*DW-1:0] ch_req_wdata;
  logic [NCH-1:0]    ch_resp_valid;
  logic              ch_resp_error;
  logic [AW-1:0]     ch_resp_addr;
  logic [DW-1:0]     ch_resp_rdata;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [AW-1:0]     mem_req_addr;
  logic              mem_req_wen;
  logic [DW-1:0]     mem_req_wdata;
  logic              mem_resp_valid;
  logic              mem_resp_error;
  logic [AW-1:0]     mem_resp_addr;
  logic [DW-1:0]     mem_resp_rdata;
  logic              orphan_resp;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int rr_m      = 0;
  int lock_id_m = 0;
  bit lock_m    = 1'b0;
  bit orphan_m  = 1'b0;
  int q_m[$];

  membus_arbiter_n #(
    .NUM_CH(NCH), .MAX_OUTSTANDING(MO), .ADDR_W(AW), .DATA_W(DW)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .ch_req_valid(ch_req_valid), .ch_req_ready(ch_req_ready),
    .ch_req_addr(ch_req_addr), .ch_req_wen(ch_req_wen), .ch_req_wdata(ch_req_wdata),
    .ch_resp_valid(ch_resp_valid), .ch_resp_error(ch_resp_error),
    .ch_resp_addr(ch_resp_addr), .ch_resp_rdata(ch_resp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_error(mem_resp_error),
    .mem_resp_addr(mem_resp_addr), .mem_resp_rdata(mem_resp_rdata),
    .orphan_resp(orphan_resp)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] addr_of(input int c);
    case (c)
      0:       return 32'hC000_0000;
      1:       return 32'hC100_0010;
      default: return 32'hC200_0020;
    endcase
  endfunction

  // expected winner among valid channels given the pointer
  function automatic int pick(input logic [2:0] v, input int rr);
    int idx;
`ifdef MEMBUS_ARB_PRIO0_EN
    if (v[0]) return 0;
    for (int k = 0; k < 2; k++) begin
      idx = ((rr == 0) ? 1 : rr) + k;
      if (idx > 2) idx = idx - 2;
      if (v[idx]) return idx;
    end
`else
    for (int k = 0; k < 3; k++) begin
      idx = (rr + k) % 3;
      if (v[idx]) return idx;
    end
`endif
    return 0;
  endfunction

  task automatic cycle(input logic [2:0] v, input logic rdy, input logic rsp);
    logic        exp_valid;
    logic        pop_ok;
    int          g;
    logic [2:0]  exp_ready;
    logic [2:0]  exp_rv;
    logic [31:0] rd;
    rd             = $urandom;
    ch_req_valid   = v;
    mem_req_ready  = rdy;
    mem_resp_valid = rsp;
    mem_resp_rdata = rd;
    mem_resp_addr  = ~rd;
    mem_resp_error = rd[0];
    @(negedge clk);
    exp_valid = (v != 3'b000) && (q_m.size() < MO);
    g         = lock_m ? lock_id_m : pick(v, rr_m);
    exp_ready = 3'b000;
    if (exp_valid && rdy) exp_ready[g] = 1'b1;
    pop_ok = rsp && (q_m.size() > 0);
    exp_rv = 3'b000;
    if (pop_ok) exp_rv[q_m[0]] = 1'b1;
    check_eq("mem_req_valid", 32'(mem_req_valid), 32'(exp_valid));
    check_eq("ch_req_ready", 32'(ch_req_ready), 32'(exp_ready));
    check_eq("mem_req_addr", mem_req_addr, exp_valid ? addr_of(g) : 32'h0);
    check_eq("mem_req_wen", 32'(mem_req_wen), 32'(exp_valid && (g == 1)));
    check_eq("ch_resp_valid", 32'(ch_resp_valid), 32'(exp_rv));
    check_eq("ch_resp_rdata", ch_resp_rdata, pop_ok ? rd : 32'h0);
    check_eq("ch_resp_addr", ch_resp_addr, pop_ok ? ~rd : 32'h0);
    check_eq("orphan_resp", 32'(orphan_resp), 32'(orphan_m));
    @(posedge clk);
    if (exp_valid && rdy) begin
      q_m.push_back(g);
      rr_m   = (g + 1) % 3;
      lock_m = 1'b0;
    end else if (exp_valid && !lock_m) begin
      lock_m    = 1'b1;
      lock_id_m = g;
    end
    if (pop_ok) void'(q_m.pop_front());
    else if (rsp) orphan_m = 1'b1;
    #1;
  endtask

  task automatic drain();
    while (q_m.size() > 0) cycle(3'b000, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    reset_n        = 1'b0;
    ch_req_valid   = '0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    q_m.delete();
    rr_m     = 0;
    lock_m   = 1'b0;
    orphan_m = 1'b0;
    @(negedge clk);
    check_eq("rst_orphan", 32'(orphan_resp), 32'h0);
    check_eq("rst_mem_req_valid", 32'(mem_req_valid), 32'h0);
    check_eq("rst_ch_req_ready", 32'(ch_req_ready), 32'h0);
    check_eq("rst_ch_resp_valid", 32'(ch_resp_valid), 32'h0);
    check_eq("rst_mem_req_addr", mem_req_addr, 32'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n        = 1'b0;
    ch_req_addr    = {addr_of(2), addr_of(1), addr_of(0)};
    ch_req_wen     = 3'b010;
    ch_req_wdata   = {32'hDDDD_0002, 32'hDDDD_0001, 32'hDDDD_0000};
    mem_resp_error = 1'b0;
    mem_resp_addr  = '0;
    mem_resp_rdata = '0;
    do_reset();

    // all valid, responses streaming: rotation and 1:1 routing
    cycle(3'b111, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cycle(3'b111, 1'b1, 1'b1);
    drain();

    // lock: ch1 pending, ch0 arrives later but cannot preempt
    cycle(3'b010, 1'b0, 1'b0);
    cycle(3'b011, 1'b0, 1'b0);
    cycle(3'b011, 1'b0, 1'b0);
    cycle(3'b011, 1'b1, 1'b0);
    cycle(3'b001, 1'b1, 1'b0);
    drain();

    // fill to MAX_OUTSTANDING, stall, pop while full, resume
    for (int i = 0; i < 5; i++) cycle(3'b111, 1'b1, 1'b0);
    cycle(3'b111, 1'b1, 1'b1);
    cycle(3'b111, 1'b1, 1'b0);
    cycle(3'b000, 1'b0, 1'b1);
    cycle(3'b000, 1'b0, 1'b1);
    // push and pop together at count 2
    cycle(3'b111, 1'b1, 1'b1);
    cycle(3'b000, 1'b0, 1'b0);
    drain();

    // stray response with empty FIFO
    cycle(3'b000, 1'b0, 1'b1);
    cycle(3'b000, 1'b0, 1'b0);
    do_reset();

    // reset mid-transaction flushes tracking
    cycle(3'b111, 1'b1, 1'b0);
    cycle(3'b111, 1'b1, 1'b0);
    do_reset();
    cycle(3'b000, 1'b0, 1'b1);
    cycle(3'b000, 1'b0, 1'b0);
    do_reset();

`ifdef MEMBUS_ARB_PRIO0_EN
    // ch0 and ch2 both valid: ch0 wins every accept
    cycle(3'b101, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cycle(3'b101, 1'b1, 1'b1);
    drain();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
